shot_scheduler: RTL and testbench

- Owns a small pool of in-flight shot slots and sequences their life cycle: allocation on trigger, per-frame motion, retirement at the top of the screen.
- Serves the renderer's position requests (peticion) round-robin over active slots.
- Sits between the player input / crosshair X logic and the shot drawing path, and is driven by the VGA hcount/vcount counters.

---
 rtl/shot_scheduler.sv | 254 +++++++++++++++++++++++++
 tb/tb_shot_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shot_scheduler.sv
// ============================================================================
// Module      : shot_scheduler
// Description : Pool of in-flight shot slots. Allocates a slot on each fire
//               rising edge, moves every live shot up once per video frame,
//               retires shots at the top of the screen and serves renderer
//               position requests round-robin over live slots.
//               Optional macro SHOT_COOLDOWN_EN adds a frame-based cooldown
//               between accepted shots.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shot_scheduler #(
    parameter int NUM_SHOTS = 4,
    parameter int START_Y   = 440,
    parameter int SPEED     = 4,
    parameter int H_MAX     = 640,
    parameter int V_MAX     = 480,
    parameter int COOLDOWN  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fire,
    input  logic [9:0] pos_x,
    input  logic [9:0] vcount,
    input  logic [9:0] hcount,
    input  logic       peticion,
    output logic [9:0] position_y,
    output logic [9:0] position_x,
    output logic       shot_valid,
    output logic [5:0] conta,
    output logic       busy
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_UPDATE = 1'b1;
    localparam logic [2:0] LAST_IDX  = 3'(NUM_SHOTS - 1);

    // Reject parameter values the 3-bit slot index and 8-bit cooldown cannot hold
    if (NUM_SHOTS < 1 || NUM_SHOTS > 8 || COOLDOWN < 0 || COOLDOWN > 255) begin : g_param_check
        $error("shot_scheduler: NUM_SHOTS must be 1..8 and COOLDOWN 0..255");
    end

    // Slot storage
    logic [9:0]           slot_x_q [NUM_SHOTS];
    logic [9:0]           slot_x_d [NUM_SHOTS];
    logic [9:0]           slot_y_q [NUM_SHOTS];
    logic [9:0]           slot_y_d [NUM_SHOTS];
    logic [NUM_SHOTS-1:0] slot_act_q, slot_act_d;

    // Control and output registers
    logic [0:0] state_q, state_d;
    logic [2:0] upd_idx_q, upd_idx_d;
    logic [2:0] rd_ptr_q, rd_ptr_d;
    logic       fire_q, fire_d;
    logic       pend_q, pend_d;
    logic [9:0] pend_x_q, pend_x_d;
    logic [9:0] out_x_q, out_x_d;
    logic [9:0] out_y_q, out_y_d;
    logic       valid_q, valid_d;
    logic [5:0] conta_q, conta_d;
    logic       busy_q, busy_d;
`ifdef SHOT_COOLDOWN_EN
    logic [7:0] cool_q, cool_d;
`endif

    // Combinational helpers
    logic       frame_tick, fire_edge, alloc, cool_ok;
    logic       free_found, rd_found;
    logic [2:0] free_idx, rd_idx;
    logic [9:0] rd_x, rd_y;
    logic [3:0] rd_dist, rd_best;

    // Next-state logic: edge detect, allocation, frame update, readout, cooldown
    always_comb begin
        slot_x_d   = slot_x_q;
        slot_y_d   = slot_y_q;
        slot_act_d = slot_act_q;
        state_d    = state_q;
        upd_idx_d  = upd_idx_q;
        rd_ptr_d   = rd_ptr_q;
        fire_d     = fire;
        pend_d     = pend_q;
        pend_x_d   = pend_x_q;
        out_x_d    = out_x_q;
        out_y_d    = out_y_q;
        valid_d    = 1'b0;
        conta_d    = conta_q;
        busy_d     = busy_q;
        alloc      = 1'b0;

        frame_tick = (hcount == 10'(H_MAX)) && (vcount == 10'(V_MAX));
        fire_edge  = fire & ~fire_q;

`ifdef SHOT_COOLDOWN_EN
        cool_d  = cool_q;
        cool_ok = (cool_q == 8'd0);
`else
        cool_ok = 1'b1;
`endif

        // Lowest-index free slot: scan downward so the smallest index wins
        free_found = 1'b0;
        free_idx   = 3'd0;
        for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
            if (!slot_act_q[i]) begin
                free_found = 1'b1;
                free_idx   = 3'(i);
            end
        end

        // Round-robin pick: smallest distance past the read pointer, own slot last
        rd_found = 1'b0;
        rd_idx   = 3'd0;
        rd_x     = 10'd0;
        rd_y     = 10'd0;
        rd_best  = 4'(NUM_SHOTS);
        rd_dist  = 4'd0;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            rd_dist = 4'(i) + 4'(NUM_SHOTS) - {1'b0, rd_ptr_q} - 4'd1;
            if (rd_dist >= 4'(NUM_SHOTS)) begin
                rd_dist = rd_dist - 4'(NUM_SHOTS);
            end
            if (slot_act_q[i] && (rd_dist < rd_best)) begin
                rd_best  = rd_dist;
                rd_found = 1'b1;
                rd_idx   = 3'(i);
                rd_x     = slot_x_q[i];
                rd_y     = slot_y_q[i];
            end
        end

        if (state_q == ST_IDLE) begin
            // A pending request is always consumed, even when it cannot be placed
            if (pend_q) begin
                pend_d = 1'b0;
                alloc  = free_found && cool_ok;
            end
            // Allocation and the frame tick share this edge; the new shot moves this frame
            if (frame_tick) begin
                state_d   = ST_UPDATE;
                upd_idx_d = 3'd0;
                busy_d    = 1'b1;
            end
        end else begin
            for (int i = 0; i < NUM_SHOTS; i++) begin
                if ((3'(i) == upd_idx_q) && slot_act_q[i]) begin
                    if (slot_y_q[i] >= 10'(SPEED)) begin
                        slot_y_d[i] = slot_y_q[i] - 10'(SPEED);
                    end else begin
                        slot_act_d[i] = 1'b0;
                    end
                end
            end
            if (upd_idx_q == LAST_IDX) begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end else begin
                upd_idx_d = upd_idx_q + 3'd1;
            end
        end

        for (int i = 0; i < NUM_SHOTS; i++) begin
            if (alloc && (3'(i) == free_idx)) begin
                slot_x_d[i]   = pend_x_q;
                slot_y_d[i]   = 10'(START_Y);
                slot_act_d[i] = 1'b1;
            end
        end

        if (alloc && (conta_q != 6'd63)) begin
            conta_d = conta_q + 6'd1;
        end

`ifdef SHOT_COOLDOWN_EN
        if (frame_tick && (cool_q != 8'd0)) begin
            cool_d = cool_q - 8'd1;
        end
        if (alloc) begin
            cool_d = 8'(COOLDOWN);
        end
`endif

        // A new edge after consumption re-arms the request; latest pos_x wins
        if (fire_edge) begin
            pend_d   = 1'b1;
            pend_x_d = pos_x;
        end

        if (peticion) begin
            if (rd_found) begin
                out_x_d  = rd_x;
                out_y_d  = rd_y;
                valid_d  = 1'b1;
                rd_ptr_d = rd_idx;
            end else begin
                out_x_d = 10'd0;
                out_y_d = 10'd0;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SHOTS; i++) begin
                slot_x_q[i] <= 10'd0;
                slot_y_q[i] <= 10'd0;
            end
            slot_act_q <= '0;
            state_q    <= ST_IDLE;
            upd_idx_q  <= 3'd0;
            rd_ptr_q   <= LAST_IDX;
            fire_q     <= 1'b0;
            pend_q     <= 1'b0;
            pend_x_q   <= 10'd0;
            out_x_q    <= 10'd0;
            out_y_q    <= 10'd0;
            valid_q    <= 1'b0;
            conta_q    <= 6'd0;
            busy_q     <= 1'b0;
`ifdef SHOT_COOLDOWN_EN
            cool_q     <= 8'd0;
`endif
        end else begin
            slot_x_q   <= slot_x_d;
            slot_y_q   <= slot_y_d;
            slot_act_q <= slot_act_d;
            state_q    <= state_d;
            upd_idx_q  <= upd_idx_d;
            rd_ptr_q   <= rd_ptr_d;
            fire_q     <= fire_d;
            pend_q     <= pend_d;
            pend_x_q   <= pend_x_d;
            out_x_q    <= out_x_d;
            out_y_q    <= out_y_d;
            valid_q    <= valid_d;
            conta_q    <= conta_d;
            busy_q     <= busy_d;
`ifdef SHOT_COOLDOWN_EN
            cool_q     <= cool_d;
`endif
        end
    end

    assign position_x = out_x_q;
    assign position_y = out_y_q;
    assign shot_valid = valid_q;
    assign conta      = conta_q;
    assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_shot_scheduler.sv
// ============================================================================
// Module      : tb_shot_scheduler
// Description : Self-checking bench for shot_scheduler. Directed scenarios
//               plus a randomized run against a behavioural slot-pool model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shot_scheduler;

    localparam int N        = 4;
    localparam int START_Y  = 440;
    localparam int SPEED    = 4;
    localparam int COOLDOWN = 8;
`ifdef SHOT_COOLDOWN_EN
    localparam bit COOL_EN = 1'b1;
`else
    localparam bit COOL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       fire;
    logic [9:0] pos_x;
    logic [9:0] vcount;
    logic [9:0] hcount;
    logic       peticion;
    logic [9:0] position_y;
    logic [9:0] position_x;
    logic       shot_valid;
    logic [5:0] conta;
    logic       busy;

    int vectors    = 0;
    int miscompares = 0;

    // Behavioural model state
    int m_act [N];
    int m_x   [N];
    int m_y   [N];
    int m_pend, m_pendx, m_fire_prev, m_conta, m_ptr, m_busy_left, m_cool;
    int m_out_x, m_out_y, m_valid;

    shot_scheduler #(
        .NUM_SHOTS (N),
        .START_Y   (START_Y),
        .SPEED     (SPEED),
        .H_MAX     (640),
        .V_MAX     (480),
        .COOLDOWN  (COOLDOWN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fire       (fire),
        .pos_x      (pos_x),
        .vcount     (vcount),
        .hcount     (hcount),
        .peticion   (peticion),
        .position_y (position_y),
        .position_x (position_x),
        .shot_valid (shot_valid),
        .conta      (conta),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock edge of the slot-pool rules, applied to the sampled inputs
    function automatic void model_edge();
        int  found, sel, s, tick, fedge, consumed, accepted, ok;
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
            end
            m_pend = 0; m_pendx = 0; m_fire_prev = 0; m_conta = 0;
            m_ptr = N - 1; m_busy_left = 0; m_cool = 0;
            m_out_x = 0; m_out_y = 0; m_valid = 0;
            return;
        end
        tick  = (hcount == 640 && vcount == 480) ? 1 : 0;
        fedge = (fire && !m_fire_prev) ? 1 : 0;

        // Readout sees the pool as it was before this edge
        if (peticion) begin
            found = 0; sel = 0;
            for (int j = 1; j <= N; j++) begin
                s = (m_ptr + j) % N;
                if (!found && m_act[s] != 0) begin
                    found = 1; sel = s;
                end
            end
            if (found) begin
                m_out_x = m_x[sel]; m_out_y = m_y[sel]; m_valid = 1; m_ptr = sel;
            end else begin
                m_out_x = 0; m_out_y = 0; m_valid = 0;
            end
        end else begin
            m_valid = 0;
        end

        consumed = 0; accepted = 0;
        ok = (!COOL_EN || m_cool == 0) ? 1 : 0;
        if (m_busy_left > 0) begin
            s = N - m_busy_left;
            if (m_act[s] != 0) begin
                if (m_y[s] >= SPEED) m_y[s] = m_y[s] - SPEED;
                else                 m_act[s] = 0;
            end
            m_busy_left--;
        end else begin
            if (m_pend != 0) begin
                consumed = 1;
                sel = -1;
                for (int i = N - 1; i >= 0; i--) if (m_act[i] == 0) sel = i;
                if (sel >= 0 && ok != 0) begin
                    m_act[sel] = 1; m_x[sel] = m_pendx; m_y[sel] = START_Y;
                    if (m_conta < 63) m_conta++;
                    accepted = 1;
                end
            end
            if (tick) m_busy_left = N;
        end
        if (COOL_EN) begin
            if (tick && m_cool > 0) m_cool--;
            if (accepted) m_cool = COOLDOWN;
        end
        if (consumed) m_pend = 0;
        if (fedge) begin
            m_pend = 1; m_pendx = int'(pos_x);
        end
        m_fire_prev = fire ? 1 : 0;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0; fire = 1'b0; peticion = 1'b0;
        pos_x = 10'd0; hcount = 10'd0; vcount = 10'd0;
        step(); step();
        reset = 1'b1;
    endtask

    task automatic fire_shot(input int x);
        fire = 1'b1; pos_x = 10'(x);
        step();
        fire = 1'b0;
        step();
    endtask

    task automatic do_frame(output int busy_cnt);
        hcount = 10'd640; vcount = 10'd480;
        step();
        busy_cnt = int'(busy);
        hcount = 10'd0; vcount = 10'd0;
        repeat (5) begin
            step();
            busy_cnt += int'(busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; fire = 1'b1; peticion = 1'b1; pos_x = 10'd123;
        hcount = 10'd0; vcount = 10'd0;
        step(); step();
        vectors++; if (shot_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0d expected 0", shot_valid); end
        vectors++; if (position_x !== 10'd0) begin miscompares++; $display("FAIL reset_pos_x: got %0d expected 0", position_x); end
        vectors++; if (position_y !== 10'd0) begin miscompares++; $display("FAIL reset_pos_y: got %0d expected 0", position_y); end
        vectors++; if (conta !== 6'd0) begin miscompares++; $display("FAIL reset_conta: got %0d expected 0", conta); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0d expected 0", busy); end
        reset = 1'b1; fire = 1'b0;
        repeat (3) step();
        vectors++; if (shot_valid !== 1'b0) begin miscompares++; $display("FAIL reset_release_valid: got %0d expected 0", shot_valid); end
        vectors++; if (conta !== 6'd0) begin miscompares++; $display("FAIL reset_release_conta: got %0d expected 0", conta); end
    endtask

    task automatic test_single_shot();
        apply_reset();
        fire_shot(200);
        peticion = 1'b1;
        step();
        peticion = 1'b0;
        vectors++; if (shot_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %0d expected 1", shot_valid); end
        vectors++; if (position_x !== 10'd200) begin miscompares++; $display("FAIL single_pos_x: got %0d expected 200", position_x); end
        vectors++; if (position_y !== 10'd440) begin miscompares++; $display("FAIL single_pos_y: got %0d expected 440", position_y); end
        vectors++; if (conta !== 6'd1) begin miscompares++; $display("FAIL single_conta: got %0d expected 1", conta); end
    endtask

    task automatic test_motion_retire();
        int bc;
        apply_reset();
        fire_shot(50);
        for (int f = 1; f <= 110; f++) begin
            do_frame(bc);
            vectors++; if (bc != 4) begin miscompares++; $display("FAIL motion_busy_cycles frame %0d: got %0d expected 4", f, bc); end
        end
        peticion = 1'b1; step(); peticion = 1'b0;
        vectors++; if (shot_valid !== 1'b1) begin miscompares++; $display("FAIL motion_valid_at_top: got %0d expected 1", shot_valid); end
        vectors++; if (position_y !== 10'd0) begin miscompares++; $display("FAIL motion_y_at_top: got %0d expected 0", position_y); end
        vectors++; if (position_x !== 10'd50) begin miscompares++; $display("FAIL motion_x_kept: got %0d expected 50", position_x); end
        do_frame(bc);
        peticion = 1'b1; step(); peticion = 1'b0;
        vectors++; if (shot_valid !== 1'b0) begin miscompares++; $display("FAIL motion_retired: got %0d expected 0", shot_valid); end
    endtask

    task automatic test_pool_full();
        int xs [5] = '{100, 150, 200, 250, 300};
        int exp_x [5] = '{100, 150, 200, 250, 100};
        apply_reset();
        for (int k = 0; k < 5; k++) fire_shot(xs[k]);
        vectors++; if (conta !== 6'd4) begin miscompares++; $display("FAIL pool_conta: got %0d expected 4", conta); end
        peticion = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            vectors++; if (position_x !== 10'(exp_x[k]) || shot_valid !== 1'b1) begin
                miscompares++; $display("FAIL pool_rr_x[%0d]: got x=%0d v=%0d expected x=%0d v=1", k, position_x, shot_valid, exp_x[k]);
            end
        end
        peticion = 1'b0;
    endtask

    task automatic test_fire_during_update();
        apply_reset();
        hcount = 10'd640; vcount = 10'd480;
        step();
        hcount = 10'd0; vcount = 10'd0;
        step();
        fire = 1'b1; pos_x = 10'd300;
        step();
        fire = 1'b0;
        step(); step();
        vectors++; if (busy !== 1'b0 || conta !== 6'd0) begin miscompares++; $display("FAIL upd_fire_before_idle: got busy=%0d conta=%0d expected busy=0 conta=0", busy, conta); end
        step();
        vectors++; if (conta !== 6'd1) begin miscompares++; $display("FAIL upd_fire_alloc: got %0d expected 1", conta); end
        peticion = 1'b1; step(); peticion = 1'b0;
        vectors++; if (position_x !== 10'd300 || position_y !== 10'd440 || shot_valid !== 1'b1) begin
            miscompares++; $display("FAIL upd_fire_slot: got x=%0d y=%0d v=%0d expected x=300 y=440 v=1", position_x, position_y, shot_valid);
        end
        step(); step();
        vectors++; if (conta !== 6'd1) begin miscompares++; $display("FAIL upd_fire_once: got %0d expected 1", conta); end
    endtask

    task automatic test_cooldown();
        int bc;
        apply_reset();
        fire_shot(10);
        repeat (3) do_frame(bc);
        fire_shot(20);
        repeat (6) do_frame(bc);
        fire_shot(30);
        vectors++; if (int'(conta) != (COOL_EN ? 2 : 3)) begin
            miscompares++; $display("FAIL cooldown_conta: got %0d expected %0d", conta, COOL_EN ? 2 : 3);
        end
    endtask

    task automatic test_random();
        int fails_shown = 0;
        apply_reset();
        for (int c = 0; c < 6000; c++) begin
            reset    = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            fire     = ($urandom_range(0, 2) == 0);
            pos_x    = 10'($urandom_range(0, 639));
            peticion = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                hcount = 10'd640; vcount = 10'd480;
            end else begin
                hcount = 10'($urandom_range(0, 639));
                vcount = 10'($urandom_range(0, 524));
            end
            step();
            vectors++;
            if (int'(shot_valid) != m_valid || int'(position_x) != m_out_x || int'(position_y) != m_out_y ||
                int'(conta) != m_conta || int'(busy) != (m_busy_left > 0 ? 1 : 0)) begin
                miscompares++;
                if (fails_shown < 20) begin
                    fails_shown++;
                    $display("FAIL random cycle %0d: got v=%0d x=%0d y=%0d conta=%0d busy=%0d expected v=%0d x=%0d y=%0d conta=%0d busy=%0d",
                             c, shot_valid, position_x, position_y, conta, busy,
                             m_valid, m_out_x, m_out_y, m_conta, (m_busy_left > 0 ? 1 : 0));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_motion_retire();
        test_pool_full();
        test_fire_during_update();
        test_cooldown();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
